// File: rtl/bcd_display_spi_if.sv
// Bus bundle between the BCD counter chain, the display transmitter and the
// output pins: refresh/digits in, busy plus the 3-wire SPI link out.
interface bcd_display_spi_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    refresh;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    busy;
    logic                    sck;
    logic                    mosi;
    logic                    cs_n;

    // Side that requests refreshes and observes the link.
    modport master (
        output refresh,
        output digits,
        input  busy,
        input  sck,
        input  mosi,
        input  cs_n
    );

    // Transmitter side.
    modport slave (
        input  refresh,
        input  digits,
        output busy,
        output sck,
        output mosi,
        output cs_n
    );
endinterface

// File: rtl/bcd_display_spi.sv
// Snapshots the BCD digit registers on refresh and writes them to a
// MAX7219-style display controller, one 16-bit register write per digit.
// The first sequence after reset is preceded by five controller set-up frames.
// All outputs come straight from flops.
module bcd_display_spi #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 4,
    parameter int INTENSITY  = 8
) (
    input  logic              clk,
    input  logic              reset,
    bcd_display_spi_if.slave  bus
);
    localparam int                DIV_W       = $clog2(CLK_DIV) + 1;
    localparam int                DW          = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]        INIT_FRAMES = 4'd5;
    localparam logic [3:0]        NUM_DIG_4   = 4'(NUM_DIGITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_LOAD_NEXT
    } state_t;

    state_t              state_r, state_s;
    logic [DIV_W-1:0]    div_r, div_s;
    logic [3:0]          bit_r, bit_s;
    logic [3:0]          frame_r, frame_s;
    logic [DW-1:0]       snap_r, snap_s;
    logic                init_done_r, init_done_s;
    logic                with_init_r, with_init_s;
    logic                busy_r, busy_s;
    logic                sck_r, sck_s;
    logic                mosi_r, mosi_s;
    logic                cs_n_r, cs_n_s;

    logic [15:0]         start_word_s;
    logic [15:0]         cur_word_s;
    logic [15:0]         next_word_s;
    logic [3:0]          last_idx_s;

    // Register-write word for frame idx of a sequence: the set-up frames
    // come first when with_init is set, then digit k goes to address k+1.
    // Nibbles A-F pass through untouched; Code-B decode renders them.
    function automatic logic [15:0] frame_word(input logic [3:0]    idx,
                                               input logic          with_init,
                                               input logic [DW-1:0] snap);
        logic [3:0]  k;
        logic [3:0]  nib;
        logic [15:0] word;
        k    = 4'd0;
        nib  = 4'h0;
        word = 16'h0000;
        if (with_init && (idx < INIT_FRAMES)) begin
            case (idx)
                4'd0:    word = 16'h0C01;
                4'd1:    word = 16'h09FF;
                4'd2:    word = {8'h0B, 4'h0, 4'(NUM_DIGITS - 1)};
                4'd3:    word = {8'h0A, 4'h0, 4'(INTENSITY)};
                4'd4:    word = 16'h0F00;
                default: word = 16'h0000;
            endcase
        end else begin
            k = with_init ? (idx - INIT_FRAMES) : idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib = (k == 4'(i)) ? snap[4*i +: 4] : nib;
            end
            word = {4'h0, k + 4'd1, 4'h0, nib};
        end
        return word;
    endfunction

    assign start_word_s = frame_word(4'd0, ~init_done_r, bus.digits);
    assign cur_word_s   = frame_word(frame_r, with_init_r, snap_r);
    assign next_word_s  = frame_word(frame_r + 4'd1, with_init_r, snap_r);
    assign last_idx_s   = with_init_r ? (INIT_FRAMES + NUM_DIG_4 - 4'd1)
                                      : (NUM_DIG_4 - 4'd1);

    // Next-state and next-output logic; LOAD/LOAD_NEXT are the first cycle
    // of bit 15's low phase, so cs_n is already low while in them.
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        bit_s       = bit_r;
        frame_s     = frame_r;
        snap_s      = snap_r;
        init_done_s = init_done_r;
        with_init_s = with_init_r;
        busy_s      = busy_r;
        sck_s       = sck_r;
        mosi_s      = mosi_r;
        cs_n_s      = cs_n_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.refresh) begin
                    state_s     = ST_LOAD;
                    snap_s      = bus.digits;
                    with_init_s = ~init_done_r;
                    frame_s     = 4'd0;
                    bit_s       = 4'd15;
                    div_s       = '0;
                    busy_s      = 1'b1;
                    sck_s       = 1'b0;
                    cs_n_s      = 1'b0;
                    mosi_s      = start_word_s[15];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD, ST_LOAD_NEXT, ST_SHIFT: begin
                state_s = ST_SHIFT;
                if (div_r == DIV_LAST) begin
                    div_s = '0;
                    if (!sck_r) begin
                        sck_s = 1'b1;
                    end else if (bit_r == 4'd0) begin
                        sck_s   = 1'b0;
                        cs_n_s  = 1'b1;
                        mosi_s  = 1'b0;
                        state_s = ST_GAP;
                    end else begin
                        sck_s  = 1'b0;
                        bit_s  = bit_r - 4'd1;
                        mosi_s = cur_word_s[bit_r - 4'd1];
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (div_r == DIV_LAST) begin
                    div_s = '0;
                    if (with_init_r && (frame_r == (INIT_FRAMES - 4'd1))) begin
                        init_done_s = 1'b1;
                    end else begin
                        init_done_s = init_done_r;
                    end
                    if (frame_r == last_idx_s) begin
                        state_s     = ST_IDLE;
                        busy_s      = 1'b0;
                        with_init_s = 1'b0;
                    end else begin
                        state_s = ST_LOAD_NEXT;
                        frame_s = frame_r + 4'd1;
                        bit_s   = 4'd15;
                        cs_n_s  = 1'b0;
                        mosi_s  = next_word_s[15];
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                sck_s   = 1'b0;
                mosi_s  = 1'b0;
                cs_n_s  = 1'b1;
            end
        endcase
    end

    // State, counters, snapshot and output flops; reset forces the idle link.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            div_r       <= '0;
            bit_r       <= 4'd0;
            frame_r     <= 4'd0;
            snap_r      <= '0;
            init_done_r <= 1'b0;
            with_init_r <= 1'b0;
            busy_r      <= 1'b0;
            sck_r       <= 1'b0;
            mosi_r      <= 1'b0;
            cs_n_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            div_r       <= div_s;
            bit_r       <= bit_s;
            frame_r     <= frame_s;
            snap_r      <= snap_s;
            init_done_r <= init_done_s;
            with_init_r <= with_init_s;
            busy_r      <= busy_s;
            sck_r       <= sck_s;
            mosi_r      <= mosi_s;
            cs_n_r      <= cs_n_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.sck  = sck_r;
    assign bus.mosi = mosi_r;
    assign bus.cs_n = cs_n_r;
endmodule

// File: tb/tb_bcd_display_spi.sv
// Bench for bcd_display_spi: decodes SPI frames from the pins, checks link
// timing continuously, and compares frame contents and busy length against
// a reference built from the register-write rules.
module tb_bcd_display_spi;
    localparam int ND        = 6;
    localparam int CD        = 3;
    localparam int INT       = 8;
    localparam int FRAME_CYC = 33 * CD;

    logic clk = 1'b0;
    logic rst;

    bcd_display_spi_if #(.NUM_DIGITS(ND)) bus ();

    bcd_display_spi #(
        .NUM_DIGITS(ND),
        .CLK_DIV   (CD),
        .INTENSITY (INT)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    typedef struct {
        logic [23:0] digits;
        bit          with_init;
        int          n_frames;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: list of register writes a sequence must produce.
    function automatic void build_expected(input logic [23:0] d, input bit with_init);
        exp_q.delete();
        if (with_init) begin
            exp_q.push_back(16'h0C01);
            exp_q.push_back(16'h09FF);
            exp_q.push_back(16'(32'h0B00 + ND - 1));
            exp_q.push_back(16'(32'h0A00 + INT));
            exp_q.push_back(16'h0F00);
        end
        for (int k = 0; k < ND; k++) begin
            exp_q.push_back(16'((k + 1) * 256 + ((d >> (4 * k)) % 16)));
        end
    endfunction

    // Pin monitor: frame decode plus timing checks, sampled on falling clk.
    int          cyc = 0;
    logic        p_sck = 1'b0, p_mosi = 1'b0, p_csn = 1'b1;
    int          last_evt = 0, last_fall = 0, last_rise = 0;
    bit          have_prev = 1'b0, busy_dropped = 1'b1;
    logic [15:0] shreg = 16'h0000;
    int          nbits = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                have_prev    = 1'b0;
                busy_dropped = 1'b1;
                nbits        = 0;
                shreg        = 16'h0000;
            end else begin
                if (!bus.busy) busy_dropped = 1'b1;
                if (p_csn && !bus.cs_n) begin
                    if (have_prev && !busy_dropped) begin
                        chk("frame_period", 64'(cyc - last_fall), 64'(FRAME_CYC));
                        chk("cs_gap", 64'(cyc - last_rise), 64'(CD));
                    end
                    have_prev    = 1'b1;
                    busy_dropped = 1'b0;
                    last_fall    = cyc;
                    last_evt     = cyc;
                    nbits        = 0;
                    shreg        = 16'h0000;
                end
                if (!bus.cs_n && !p_sck && bus.sck) begin
                    chk("sck_low_len", 64'(cyc - last_evt), 64'(CD));
                    chk("mosi_stable_rise", 64'(bus.mosi), 64'(p_mosi));
                    shreg    = {shreg[14:0], bus.mosi};
                    nbits++;
                    last_evt = cyc;
                end
                if (p_sck && !bus.sck) begin
                    chk("sck_high_len", 64'(cyc - last_evt), 64'(CD));
                    last_evt = cyc;
                end
                if (bus.mosi !== p_mosi) begin
                    chk("mosi_change_edge", 64'((p_sck && !bus.sck) || (p_csn && !bus.cs_n)), 64'(1));
                end
                if (!p_csn && bus.cs_n) begin
                    chk("frame_bits", 64'(nbits), 64'(16));
                    chk("gap_idle", 64'({bus.sck, bus.mosi}), 64'(0));
                    got_q.push_back(shreg);
                    last_rise = cyc;
                end
            end
            p_sck  = bus.sck;
            p_mosi = bus.mosi;
            p_csn  = bus.cs_n;
        end
    end

    // Pulse refresh for one sampled edge; returns on the first sample after it.
    task automatic start_seq(input logic [23:0] d);
        @(negedge clk);
        got_q.delete();
        bus.digits  = d;
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
    endtask

    // Run one sequence, optionally poking refresh/digits at busy cycle poke_at.
    task automatic run_seq(input logic [23:0] d, input bit with_init, input int n_frames,
                           input string tag, input int poke_at, input logic [23:0] d_poke);
        int          len;
        logic [15:0] g;
        build_expected(d, with_init);
        start_seq(d);
        chk({tag, "_busy_rise"}, 64'(bus.busy), 64'(1));
        len = 0;
        while (bus.busy && len < 20 * FRAME_CYC) begin
            if (len == poke_at) begin
                bus.refresh = 1'b1;
                bus.digits  = d_poke;
            end else begin
                bus.refresh = 1'b0;
            end
            len++;
            @(negedge clk);
        end
        bus.refresh = 1'b0;
        chk({tag, "_busy_len"}, 64'(len), 64'(n_frames * FRAME_CYC));
        chk({tag, "_nframes"}, 64'(got_q.size()), 64'(n_frames));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            chk($sformatf("%s_word%0d", tag, i), 64'(g), 64'(exp_q[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst         = 1'b1;
        bus.refresh = 1'b0;
        bus.digits  = '0;

        // Reset defaults and a quiet idle link.
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bus.busy, bus.sck, bus.mosi, bus.cs_n}), 64'(4'b0001));
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.sck || bus.busy) cnt++;
        end
        chk("idle_no_sck", 64'(cnt), 64'(0));

        // Vector table: first entry carries the set-up frames.
        vecs[0] = '{24'h123456, 1'b1, ND + 5};
        vecs[1] = '{24'h095900, 1'b0, ND};
        vecs[2] = '{24'hFEDCBA, 1'b0, ND};
        for (int i = 3; i < 6; i++) vecs[i] = '{24'($urandom), 1'b0, ND};
        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].digits, vecs[i].with_init, vecs[i].n_frames,
                    $sformatf("vec%0d", i), -1, 24'h0);
            repeat (5) @(negedge clk);
        end

        // Refresh and digit change while busy: one sequence, original snapshot.
        run_seq(24'h314159, 1'b0, ND, "busyref", 50, 24'h999999);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
        chk("busyref_no_requeue", 64'(cnt), 64'(0));
        chk("busyref_frames_after", 64'(got_q.size()), 64'(ND));

        // Reset during bit 7 of the first digit frame.
        start_seq(24'h808080);
        repeat (16 * CD + 1) @(negedge clk);
        chk("midframe_active", 64'({bus.busy, bus.cs_n}), 64'(2'b10));
        #2 rst = 1'b1;
        #1 chk("midframe_reset_outputs", 64'({bus.busy, bus.sck, bus.mosi, bus.cs_n}), 64'(4'b0001));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_seq(24'h271828, 1'b1, ND + 5, "after_reset", -1, 24'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
